uart_rx: RTL
============

# uart_rx

Oversampling UART receiver: takes the asynchronous serial input `rxd`, synchronises it, finds start bits on `sample_tick`, samples each bit at its centre, and presents bytes through a one-entry valid/ready buffer. Sits between the pad and the UART MMIO/FIFO logic. Consumes `sample_tick` from `uart_baud_gen` (OVERSAMPLE_RATE ticks per bit); `baud_tick` is not used.

## Interface
- `DATA_BITS`, 8, data bits per frame; 8N1 framing (no parity, 1 stop bit).
- `OS`, `uart_defines::OVERSAMPLE_RATE` (16), sample ticks per bit; even, ≥ 4.
- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `sample_tick`  in  1  one-`clk` pulse, OS per bit period.
- `rxd`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  DATA_BITS  received byte; LSB is the first bit received.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid` is also high.
- `frame_err`  out  1  one-`clk` pulse: stop bit sampled low.
- `overrun_err`  out  1  one-`clk` pulse: completed byte dropped because the buffer was full.

## Operation
- `rxd` passes through a 2-flop synchronizer that resets to 1. All FSM decisions use the synchronised `rxd_s`.
- State and counters change only in cycles where `sample_tick` = 1. The exceptions are the handshake and the error pulses.
- Counters: `tick_cnt` is $clog2(OS) bits and wraps to 0 at compare. `bit_cnt` is $clog2(DATA_BITS+1) bits.
- IDLE:
  - `rxd_s` = 0 → START, `tick_cnt` = 0.
- START:
  - At `tick_cnt` = OS/2−1 with `rxd_s` = 0 → DATA, `tick_cnt` = 0, `bit_cnt` = 0.
  - At that point with `rxd_s` = 1 → IDLE. This is a glitch: no flags.
- DATA:
  - At `tick_cnt` = OS−1: shift `rxd_s` into the MSB of the shift register (right shift), `tick_cnt` = 0, `bit_cnt`++.
  - After DATA_BITS bits → STOP.
- STOP, at `tick_cnt` = OS−1:
  - `rxd_s` = 1: deliver the byte (see buffer rules) → IDLE.
  - `rxd_s` = 0: pulse `frame_err`, discard the byte → BREAK.
- BREAK:
  - Remain until `rxd_s` = 1 on a `sample_tick`, then → IDLE. This prevents a held-low line from being taken as repeated starts.
- Buffer rules:
  - Handshake: `rx_valid` && `rx_ready` clears `rx_valid` next cycle.
  - Delivery with the buffer empty, or being consumed in the same cycle: load `rx_data`, set `rx_valid`. No overrun.
  - Delivery with `rx_valid` = 1 and `rx_ready` = 0: keep the old byte, drop the new one, pulse `overrun_err`.
- Reset (any time, including mid-frame):
  - FSM → IDLE; counters and shift register 0.
  - Synchronizer flops 1.
  - `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun_err` = 0.

## Timing
- Synchronizer latency: 2 `clk` from `rxd` to `rxd_s`.
- Let T0 be the `sample_tick` on which IDLE sees `rxd_s` = 0.
- The start bit is checked at T0 + OS/2 ticks.
- Data bit i (0-based) is sampled at T0 + OS/2 + OS·(i+1) ticks.
- The stop bit is sampled at T0 + OS/2 + OS·(DATA_BITS+1) ticks.
- `rx_valid`, `rx_data`, `frame_err` and `overrun_err` update on the `clk` edge after the stop-bit sample tick.
- Error pulses are exactly 1 `clk` wide.
- IDLE is re-entered about half a bit before the stop bit ends, so back-to-back frames are received with no gap.
- `rx_valid` is held high until the handshake; `rx_data` is stable while `rx_valid` = 1.

## Structure
- In `uart_defines`:
  - `typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} uart_rx_state_t`.
  - `UART_DATA_BITS` = 8, alongside the existing `OVERSAMPLE_RATE`, `BAUD_RATE` and `CLK_FREQ`.
- One sub-module, `uart_sync2`: a 2-flop synchronizer with parameter `RESET_VAL` (1 here). It is reusable for `cts`/GPIO inputs.
- The bench instantiates `uart_baud_gen` to drive `sample_tick`.

## Test plan
- Frame 0x55 at nominal baud, `rx_ready` = 1 → `rx_valid` pulses 1 cycle with `rx_data` = 0x55; no error flags.
- `rxd` low for 4 sample ticks, then high → no `rx_valid`, no flags, FSM back in IDLE. A following frame 0xA5 is received correctly.
- Frame 0x3C with the stop bit driven 0, then the line held low for 3 bit times → one `frame_err` pulse, no `rx_valid`. The next frame 0x81 is received only after the line returns high.
- Back-to-back frames 0xA5, 0x3C with `rx_ready` = 0 → `rx_data` stays 0xA5, one `overrun_err` pulse at the second stop bit. Repeat with `rx_ready` raised in exactly the load cycle → `rx_data` = 0x3C, no `overrun_err`.
- `rstn` asserted during data bit 4 of 0xF0 → all outputs 0 next cycle. The following frame 0xC3 is received correctly.
- Frames 0x00 and 0xFF with baud skewed ±3% → correct bytes, no errors.

Source files
------------

// File: rtl/uart_defines.sv
// Shared UART constants and the receiver state encoding.
package uart_defines;
  localparam int CLK_FREQ        = 50_000_000;
  localparam int BAUD_RATE       = 115_200;
  localparam int OVERSAMPLE_RATE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} uart_rx_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// Tick generator: sample_tick every DIV clocks, baud_tick every OS sample ticks.
module uart_baud_gen import uart_defines::*; #(
  parameter int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE_RATE),
  parameter int OS  = OVERSAMPLE_RATE
) (
  input  logic clk,
  input  logic rstn,
  output logic sample_tick,
  output logic baud_tick
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW = $clog2(OS);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST  = OW'(OS - 1);

  logic [DW-1:0] div_q;
  logic [OW-1:0] os_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_q       <= '0;
      os_q        <= '0;
      sample_tick <= 1'b0;
      baud_tick   <= 1'b0;
    end else begin
      sample_tick <= (div_q == DIV_LAST);
      baud_tick   <= (div_q == DIV_LAST) && (os_q == OS_LAST);
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        os_q  <= (os_q == OS_LAST) ? '0 : os_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs (rxd, cts, GPIO).
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q <= RESET_VAL;
      q_o    <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with a one-entry valid/ready output buffer.
module uart_rx import uart_defines::*; #(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int OS        = OVERSAMPLE_RATE
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sample_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err
);
  localparam int TW = $clog2(OS);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF     = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] FULL     = TW'(OS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_rx_state_t       state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 valid_q, valid_d, ferr_q, ferr_d, oerr_q, oerr_d;
  logic                 rxd_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (rxd),
    .q_o  (rxd_s)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (sample_tick) begin
      case (state_q)
        RX_IDLE: if (!rxd_s) begin
          state_d = RX_START;
          tick_d  = '0;
        end
        RX_START: begin
          if (tick_q == HALF) begin
            // A start bit that is high again at its centre was a glitch.
            if (rxd_s) state_d = RX_IDLE;
            else begin
              state_d = RX_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end
          end else tick_d = tick_q + 1'b1;
        end
        RX_DATA: begin
          if (tick_q == FULL) begin
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) state_d = RX_STOP;
          end else tick_d = tick_q + 1'b1;
        end
        RX_STOP: begin
          if (tick_q == FULL) begin
            tick_d = '0;
            if (rxd_s) begin
              state_d = RX_IDLE;
              // A byte consumed in this same cycle frees the slot for the new one.
              if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end else oerr_d = 1'b1;
            end else begin
              ferr_d  = 1'b1;
              state_d = RX_BREAK;
            end
          end else tick_d = tick_q + 1'b1;
        end
        RX_BREAK: if (rxd_s) state_d = RX_IDLE;
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
endmodule
